mcycle_sequencer: RTL and testbench
===================================

// Module: mcycle_sequencer
// PURPOSE
//  Generates T-state/M-cycle timing for the CPU core: steps each instruction through a fetch M-cycle, then its
//  decoder-reported execute M-cycles. Issues bus requests, stretches T2 for bus wait states, and strobes register-file
//  writeback into r1. Sits between fetch/decode and the datapath inside top; also handles HALT (opcode 0x76).
// PARAMETERS
//  OP_SIZE    8      opcode width
//  MAX_MCYC   6      maximum M-cycles per instruction (fetch included)
//  HALT_OP    8'h76  opcode that enters HALT after completing
// PORTS
//  clk           in   1          core clock; all state changes on posedge
//  rst           in   1          synchronous active-low reset
//  op_next       in   OP_SIZE    opcode on bus, sampled at M0 T3
//  mcyc_total    in   3          M-cycles of latched opcode (decoder); valid from M0 T4; 0 treated as 1, >MAX_MCYC clamped
//  mem_map       in   MAX_MCYC   bit i=1: M-cycle i accesses bus; bit0 forced 1 internally
//  mem_ready     in   1          bus ready; sampled at T2 of access M-cycles
//  irq_pending   in   1          interrupt pending; only used in HALT
//  t_state       out  4          one-hot T1..T4 (bit0=T1); 4'b0000 when not running
//  m_cycle       out  3          current M-cycle index, 0=fetch
//  ir            out  OP_SIZE    latched opcode
//  ir_load       out  1          1-cycle pulse in cycle ir updates (M0 T3)
//  mem_req       out  1          high T1..T3 of access M-cycles, incl. wait cycles
//  rf_we         out  1          1-cycle pulse at T4 of final M-cycle
//  instr_done    out  1          coincident with rf_we
//  halted        out  1          high while in S_HALT
// BEHAVIOUR
//  Reset (rst=0 at posedge, any state, mid-instruction included): state=S_RESET; t_state=0, m_cycle=0, ir=8'h00,
//   ir_load=0, mem_req=0, rf_we=0, instr_done=0, halted=0. Partial instruction discarded, no writeback.
//  States:
//   S_RESET -> S_RUN: first cycle with rst=1; outputs stay at reset values; next cycle is M0 T1.
//   S_RUN: T advances T1->T2->T3->T4 each clk.
//    At T4: if m_cycle < len-1, m_cycle++ and T1. Else:
//     - rf_we/instr_done pulse;
//     - if ir==HALT_OP go S_HALT, else m_cycle=0 and T1.
//   S_WAIT: entered from T2 of an access M-cycle when mem_ready=0; t_state held at T2 and mem_req held high.
//    Each cycle mem_ready is resampled; mem_ready=1 -> T3 next cycle in S_RUN. Unbounded wait.
//   S_HALT: t_state=0, mem_req=0, halted=1. irq_pending=1 -> next cycle M0 T1 (halted=0).
//    irq_pending at the HALT instruction's own T4 does not skip S_HALT: minimum 1 cycle in S_HALT.
//  Timing:
//   - Each T-state is 1 clk with no wait states: 1-M-cycle instruction = 4 clk, n M-cycles = 4n clk.
//   - ir captures op_next at M0 T3 (after any M0 wait completes).
//   - len = mcyc_total and mem_map are sampled once at M0 T4 into internal registers; mid-instruction changes are ignored.
//   - mem_ready is ignored outside T2 of access M-cycles and during non-access M-cycles.
//  Back-to-back: the next instruction's M0 T1 immediately follows the previous T4; there is no idle cycle.
// CONFIGURATION
//  SEQ_STEP_EN defined: adds inputs step_en (1) and step_go (1), plus state S_STEP.
//   - If step_en=1 at final T4, enter S_STEP instead of M0 T1: t_state=0, mem_req=0.
//   - A step_go=1 cycle -> M0 T1 next cycle.
//   - HALT takes priority over S_STEP. Reset clears S_STEP.
//   - step_en=0 -> behaviour identical to undefined.
//  SEQ_STEP_EN undefined: no extra ports or state.
// TESTING
//  1 rst=0 2 clk then rst=1, op_next=8'h00, mcyc_total=1, mem_ready=1 -> 1 clk t_state=0; then t_state 1,2,4,8 repeat;
//    rf_we every 4th clk; ir=8'h00.
//  2 op_next=8'h01, mcyc_total=3, mem_map=6'b000111 -> m_cycle 0,1,2; mem_req high T1-T3 of each;
//    rf_we once after 12 clk.
//  3 as 2 with mem_ready=0 for 3 clk at M1 T2 -> t_state=4'b0010 held 4 clk, mem_req held, rf_we after 15 clk.
//  4 op_next=8'h76, mcyc_total=1 -> halted=1 after 4 clk, t_state=0;
//    irq_pending=1 at clk 10 -> M0 T1 at clk 11, halted=0.
//  5 rst=0 at M1 T3 of 3-cycle op -> next cycle all outputs at reset values, no rf_we; restart at M0 after S_RESET.
//  6 SEQ_STEP_EN, step_en=1 -> stalls in S_STEP after each rf_we; step_go pulse -> exactly one instruction then stall.

Source files
------------

// File: rtl/mcycle_sequencer.sv
// T-state / M-cycle timing generator: fetch plus decoder-sized execute M-cycles, bus wait stretching, HALT.
// Optional single-step stall state is compiled in when SEQ_STEP_EN is defined.
module mcycle_sequencer #(
  parameter int unsigned        OP_SIZE  = 8,
  parameter int unsigned        MAX_MCYC = 6,
  parameter logic [OP_SIZE-1:0] HALT_OP  = 8'h76
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OP_SIZE-1:0]  op_next,
  input  logic [2:0]          mcyc_total,
  input  logic [MAX_MCYC-1:0] mem_map,
  input  logic                mem_ready,
  input  logic                irq_pending,
`ifdef SEQ_STEP_EN
  input  logic                step_en,
  input  logic                step_go,
`endif
  output logic [3:0]          t_state,
  output logic [2:0]          m_cycle,
  output logic [OP_SIZE-1:0]  ir,
  output logic                ir_load,
  output logic                mem_req,
  output logic                rf_we,
  output logic                instr_done,
  output logic                halted
);

`ifdef SEQ_STEP_EN
  typedef enum logic [2:0] {
    S_RESET = 3'd0, S_RUN = 3'd1, S_WAIT = 3'd2, S_HALT = 3'd3, S_STEP = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    S_RESET = 3'd0, S_RUN = 3'd1, S_WAIT = 3'd2, S_HALT = 3'd3
  } state_t;
`endif

  localparam logic [3:0] T1 = 4'b0001;
  localparam logic [3:0] T2 = 4'b0010;
  localparam logic [3:0] T3 = 4'b0100;
  localparam logic [3:0] T4 = 4'b1000;
  localparam logic [2:0] MAX_LEN = 3'(MAX_MCYC);

  state_t              state_r, state_s;
  logic [3:0]          t_r, t_s;
  logic [2:0]          m_r, m_s;
  logic [OP_SIZE-1:0]  ir_r, ir_s;
  logic                ir_load_r, ir_load_s;
  logic                mem_req_r, mem_req_s;
  logic                rf_we_r, rf_we_s;
  logic                halted_r, halted_s;
  logic [2:0]          len_r, len_s, len_in_s, len_eff_s;
  logic [7:0]          map_r, map_s, map_in_s, map_eff_s;
  logic                access_s, last_s;

  function automatic logic [2:0] clamp_len(input logic [2:0] n);
    logic [2:0] r;
    if (n == 3'd0) begin
      r = 3'd1;
    end else if (n > MAX_LEN) begin
      r = MAX_LEN;
    end else begin
      r = n;
    end
    return r;
  endfunction

  // During M0 the decoder inputs are live; afterwards the values latched at M0 T4 rule.
  assign len_in_s  = clamp_len(mcyc_total);
  assign map_in_s  = 8'(mem_map) | 8'h01;
  assign len_eff_s = (m_r == 3'd0) ? len_in_s : len_r;
  assign map_eff_s = (m_r == 3'd0) ? map_in_s : map_r;
  assign access_s  = map_eff_s[m_r];
  assign last_s    = ((m_r + 3'd1) >= len_eff_s);

  // Next-state and next-output computation.
  always_comb begin
    state_s = state_r;
    t_s     = t_r;
    m_s     = m_r;
    rf_we_s = 1'b0;
    len_s   = len_r;
    map_s   = map_r;
    case (state_r)
      S_RESET: begin
        state_s = S_RUN;
        t_s     = T1;
        m_s     = 3'd0;
      end
      S_RUN: begin
        case (t_r)
          T1: t_s = T2;
          T2: begin
            if (access_s && !mem_ready) begin
              state_s = S_WAIT;
            end else begin
              t_s = T3;
            end
          end
          T3: t_s = T4;
          T4: begin
            if (m_r == 3'd0) begin
              len_s = len_in_s;
              map_s = map_in_s;
            end else begin
              len_s = len_r;
            end
            if (!last_s) begin
              m_s = m_r + 3'd1;
              t_s = T1;
            end else begin
              rf_we_s = 1'b1;
              m_s     = 3'd0;
              if (ir_r == HALT_OP) begin
                state_s = S_HALT;
                t_s     = 4'b0000;
              end
`ifdef SEQ_STEP_EN
              else if (step_en) begin
                state_s = S_STEP;
                t_s     = 4'b0000;
              end
`endif
              else begin
                t_s = T1;
              end
            end
          end
          default: begin
            state_s = S_RESET;
            t_s     = 4'b0000;
            m_s     = 3'd0;
          end
        endcase
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_s = S_RUN;
          t_s     = T3;
        end else begin
          t_s = T2;
        end
      end
      S_HALT: begin
        if (irq_pending) begin
          state_s = S_RUN;
          t_s     = T1;
          m_s     = 3'd0;
        end else begin
          t_s = 4'b0000;
        end
      end
`ifdef SEQ_STEP_EN
      S_STEP: begin
        if (step_go) begin
          state_s = S_RUN;
          t_s     = T1;
          m_s     = 3'd0;
        end else begin
          t_s = 4'b0000;
        end
      end
`endif
      default: begin
        state_s = S_RESET;
        t_s     = 4'b0000;
        m_s     = 3'd0;
      end
    endcase

    // Opcode is captured on the way into M0 T3, whether or not a wait preceded it.
    ir_load_s = (state_s == S_RUN) && (t_r == T2) && (t_s == T3) && (m_r == 3'd0);
    ir_s      = ir_load_s ? op_next : ir_r;
    mem_req_s = ((state_s == S_RUN) || (state_s == S_WAIT)) &&
                (t_s[0] || t_s[1] || t_s[2]) && map_s[m_s];
    halted_s  = (state_s == S_HALT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= S_RESET;
      t_r       <= 4'b0000;
      m_r       <= 3'd0;
      ir_r      <= '0;
      ir_load_r <= 1'b0;
      mem_req_r <= 1'b0;
      rf_we_r   <= 1'b0;
      halted_r  <= 1'b0;
      len_r     <= 3'd1;
      map_r     <= 8'h01;
    end else begin
      state_r   <= state_s;
      t_r       <= t_s;
      m_r       <= m_s;
      ir_r      <= ir_s;
      ir_load_r <= ir_load_s;
      mem_req_r <= mem_req_s;
      rf_we_r   <= rf_we_s;
      halted_r  <= halted_s;
      len_r     <= len_s;
      map_r     <= map_s;
    end
  end

  assign t_state    = t_r;
  assign m_cycle    = m_r;
  assign ir         = ir_r;
  assign ir_load    = ir_load_r;
  assign mem_req    = mem_req_r;
  assign rf_we      = rf_we_r;
  assign instr_done = rf_we_r;
  assign halted     = halted_r;

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Self-checking bench for mcycle_sequencer: per-cycle T/M checks plus a completion scoreboard
// (opcode and writeback cycle pushed at issue, popped on each rf_we).
module tb_mcycle_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] op_next;
  logic [2:0] mcyc_total;
  logic [5:0] mem_map;
  logic       mem_ready;
  logic       irq_pending;
`ifdef SEQ_STEP_EN
  logic       step_en;
  logic       step_go;
`endif
  logic [3:0] t_state;
  logic [2:0] m_cycle;
  logic [7:0] ir;
  logic       ir_load, mem_req, rf_we, instr_done, halted;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] done;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;

  mcycle_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .op_next     (op_next),
    .mcyc_total  (mcyc_total),
    .mem_map     (mem_map),
    .mem_ready   (mem_ready),
    .irq_pending (irq_pending),
`ifdef SEQ_STEP_EN
    .step_en     (step_en),
    .step_go     (step_go),
`endif
    .t_state     (t_state),
    .m_cycle     (m_cycle),
    .ir          (ir),
    .ir_load     (ir_load),
    .mem_req     (mem_req),
    .rf_we       (rf_we),
    .instr_done  (instr_done),
    .halted      (halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Advance one clock, sample just after the edge and retire any completed instruction.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    check("instr_done", 32'(instr_done), 32'(rf_we));
    if (rf_we) begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("done_cycle", 32'(cyc), e.done);
        check("done_ir", 32'(ir), 32'(e.op));
      end else begin
        check("rf_we_unexpected", 32'(rf_we), 32'd0);
      end
    end
  endtask

  // Run one instruction from its M0 T1; optionally hold mem_ready low for wn samples at M(wm) T2.
  task automatic issue(input logic [7:0] op, input logic [2:0] total, input logic [5:0] map,
                       input int wm, input int wn);
    int         n;
    int         extra;
    logic [5:0] mapf;
    exp_t       e;
    n     = (total == 3'd0) ? 1 : ((total > 3'd6) ? 6 : int'(total));
    mapf  = map | 6'b000001;
    extra = (wn > 0 && wm < n && mapf[wm]) ? wn : 0;
    e.op   = op;
    e.done = 32'(cyc + 4 * n + extra);
    sb.push_back(e);
    op_next    = op;
    mcyc_total = total;
    mem_map    = map;
    for (int m = 0; m < n; m++) begin
      for (int t = 0; t < 4; t++) begin
        check("t_state", 32'(t_state), 32'(4'b0001 << t));
        check("m_cycle", 32'(m_cycle), 32'(m));
        check("mem_req", 32'(mem_req), 32'(mapf[m] && t < 3));
        check("ir_load", 32'(ir_load), 32'(m == 0 && t == 2));
        check("halted_run", 32'(halted), 32'd0);
        if (m == 0 && t == 2) check("ir_capture", 32'(ir), 32'(op));
        if (t == 1 && m == wm && wn > 0) begin
          mem_ready = 1'b0;
          if (mapf[m]) begin
            for (int w = 1; w <= wn; w++) begin
              tick();
              check("wait_t_state", 32'(t_state), 32'd2);
              check("wait_mem_req", 32'(mem_req), 32'd1);
              if (w == wn) mem_ready = 1'b1;
            end
          end
        end
        if (m == 1 && t == 0) begin
          mcyc_total = 3'd1;
          mem_map    = 6'b000000;
          op_next    = ~op;
        end
        tick();
        mem_ready = 1'b1;
      end
    end
  endtask

  initial begin
    rst         = 1'b0;
    op_next     = 8'h00;
    mcyc_total  = 3'd1;
    mem_map     = 6'b000001;
    mem_ready   = 1'b1;
    irq_pending = 1'b0;
`ifdef SEQ_STEP_EN
    step_en     = 1'b0;
    step_go     = 1'b0;
`endif
    tick();
    tick();
    check("reset_outputs", 32'({t_state, m_cycle, ir, ir_load, mem_req, rf_we, instr_done, halted}), 32'd0);
    rst = 1'b1;
    check("s_reset_t_state", 32'(t_state), 32'd0);
    tick();

    repeat (3) issue(8'h00, 3'd1, 6'b000001, 0, 0);
    issue(8'h01, 3'd3, 6'b000111, 0, 0);
    issue(8'h01, 3'd3, 6'b000111, 1, 3);
    issue(8'h3c, 3'd2, 6'b000001, 0, 2);
    issue(8'h5a, 3'd3, 6'b000101, 1, 2);
    issue(8'h11, 3'd0, 6'b000001, 0, 0);
    issue(8'h22, 3'd7, 6'b101010, 5, 1);

    // HALT with interrupt already pending: still one cycle halted.
    irq_pending = 1'b1;
    issue(8'h76, 3'd1, 6'b000001, 0, 0);
    check("halt_min_halted", 32'(halted), 32'd1);
    check("halt_min_t_state", 32'(t_state), 32'd0);
    check("halt_min_mem_req", 32'(mem_req), 32'd0);
    tick();
    irq_pending = 1'b0;
    check("halt_exit_halted", 32'(halted), 32'd0);
    check("halt_exit_t_state", 32'(t_state), 32'd1);

    issue(8'h76, 3'd2, 6'b000011, 0, 0);
    repeat (5) begin
      check("halt_hold_halted", 32'(halted), 32'd1);
      check("halt_hold_t_state", 32'(t_state), 32'd0);
      check("halt_hold_mem_req", 32'(mem_req), 32'd0);
      tick();
    end
    irq_pending = 1'b1;
    check("halt_irq_halted", 32'(halted), 32'd1);
    tick();
    irq_pending = 1'b0;
    check("halt_irq_exit_halted", 32'(halted), 32'd0);
    check("halt_irq_exit_t_state", 32'(t_state), 32'd1);
    check("halt_irq_exit_m_cycle", 32'(m_cycle), 32'd0);

    // Reset in the middle of a 3-M-cycle instruction: nothing retires.
    op_next    = 8'h01;
    mcyc_total = 3'd3;
    mem_map    = 6'b000111;
    repeat (6) tick();
    check("pre_reset_m_cycle", 32'(m_cycle), 32'd1);
    check("pre_reset_t_state", 32'(t_state), 32'd4);
    rst = 1'b0;
    tick();
    check("mid_reset_outputs", 32'({t_state, m_cycle, ir, ir_load, mem_req, rf_we, instr_done, halted}), 32'd0);
    rst = 1'b1;
    check("mid_reset_s_reset", 32'(t_state), 32'd0);
    tick();
    issue(8'h02, 3'd1, 6'b000001, 0, 0);
    check("restart_t_state", 32'(t_state), 32'd1);

`ifdef SEQ_STEP_EN
    step_en = 1'b1;
    issue(8'h03, 3'd1, 6'b000001, 0, 0);
    repeat (3) begin
      check("step_stall_t_state", 32'(t_state), 32'd0);
      check("step_stall_mem_req", 32'(mem_req), 32'd0);
      tick();
    end
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    issue(8'h04, 3'd2, 6'b000011, 0, 0);
    check("step_one_only", 32'(t_state), 32'd0);
    tick();
    check("step_still_stalled", 32'(t_state), 32'd0);
    irq_pending = 1'b1;
    step_go = 1'b1;
    tick();
    step_go = 1'b0;
    issue(8'h76, 3'd1, 6'b000001, 0, 0);
    check("step_halt_priority", 32'(halted), 32'd1);
    step_en = 1'b0;
    tick();
    irq_pending = 1'b0;
    check("step_halt_exit", 32'(t_state), 32'd1);
`endif

    issue(8'h05, 3'd1, 6'b000001, 0, 0);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
